// File: rtl/twiddle_seq_pkg.sv
// Shared constants for the R2SDF twiddle sequencer: FSM states, control payload, span helpers.
`ifndef C2LOG_FFT_POINTS
`define C2LOG_FFT_POINTS 4
`endif
`ifndef DATA_IN_WIDTH
`define DATA_IN_WIDTH 16
`endif

package twiddle_seq_pkg;

  localparam int unsigned LOG_N  = `C2LOG_FFT_POINTS;
  localparam int unsigned N      = 1 << LOG_N;
  localparam int unsigned DATA_W = `DATA_IN_WIDTH;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  // Control bits that must line up with twiddle ROM data
  typedef struct packed {
    logic bf_sel;
    logic mul_en;
    logic out_valid;
    logic frame_done;
  } ctrl_t;

  localparam int unsigned CTRL_W = $bits(ctrl_t);

  // Butterfly span D of a 1-based stage
  function automatic int unsigned span_of(input int unsigned stage);
    return 1 << (LOG_N - stage);
  endfunction

  // Twiddle address stride exponent of a 1-based stage
  function automatic int unsigned stride_shift(input int unsigned stage);
    return stage - 1;
  endfunction

endpackage

// File: rtl/twiddle_seq_align.sv
// Optional one-cycle delay that lines control bits up with registered ROM data.
module tw_align_pipe #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DELAY = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] d_q;

  always_ff @(posedge clk) begin
    if (!rst_n) d_q <= '0;
    else        d_q <= d;
  end

  assign q = (DELAY != 0) ? d_q : d;

endmodule

// File: rtl/twiddle_seq.sv
// Twiddle address and butterfly control sequencer for one R2SDF FFT stage.
module twiddle_seq
  import twiddle_seq_pkg::*;
#(
  parameter int unsigned FFT_STAGE = 1,
  parameter int unsigned TW_FF     = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             in_valid,
  output logic [LOG_N-1:0] tw_addr,
  output logic             bf_sel,
  output logic             mul_en,
  output logic             out_valid,
  output logic             busy,
  output logic             frame_done
);

  localparam int unsigned      SPAN       = span_of(FFT_STAGE);
  localparam int unsigned      PH_BIT     = LOG_N - FFT_STAGE;
  localparam int unsigned      SHIFT      = stride_shift(FFT_STAGE);
  localparam logic [LOG_N-1:0] SPAN_MASK  = LOG_N'(SPAN - 1);
  localparam logic [LOG_N-1:0] SPAN_CNT   = LOG_N'(SPAN);
  localparam logic [LOG_N-1:0] CNT_LAST   = LOG_N'(N - 1);
  localparam logic [LOG_N-1:0] FLUSH_LAST = LOG_N'(SPAN - 1);

  state_t           state, state_d;
  logic [LOG_N-1:0] cnt, cnt_d, tw_addr_d;
  logic             step, ph, first, last, mul, busy_d;
  ctrl_t            ctrl_d, ctrl_q, ctrl_a;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state;
    cnt_d     = cnt;
    step      = 1'b0;
    ph        = 1'b0;
    first     = 1'b0;
    last      = 1'b0;
    tw_addr_d = tw_addr;
    case (state)
      ST_IDLE: begin
        tw_addr_d = '0;
        if (start) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end
      end
      ST_RUN: begin
        if (in_valid) begin
          step  = 1'b1;
          ph    = cnt[PH_BIT];
          // Delay line is still filling during the first D samples
          first = (cnt < SPAN_CNT);
          cnt_d = cnt + LOG_N'(1);
          if (cnt == CNT_LAST) state_d = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        step  = 1'b1;
        cnt_d = cnt + LOG_N'(1);
        if (cnt == FLUSH_LAST) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          last    = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
    mul = step & ~ph & ~first;
    if (step) tw_addr_d = mul ? ((cnt & SPAN_MASK) << SHIFT) : '0;
    ctrl_d.bf_sel     = step & ph;
    ctrl_d.mul_en     = mul;
    ctrl_d.out_valid  = step & ~first;
    ctrl_d.frame_done = last;
    busy_d            = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tw_addr <= '0;
      ctrl_q  <= '0;
      busy    <= 1'b0;
    end else begin
      tw_addr <= tw_addr_d;
      ctrl_q  <= ctrl_d;
      busy    <= busy_d;
    end
  end

  tw_align_pipe #(
    .WIDTH (CTRL_W),
    .DELAY (TW_FF)
  ) u_align (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (ctrl_q),
    .q     (ctrl_a)
  );

  assign bf_sel     = ctrl_a.bf_sel;
  assign mul_en     = ctrl_a.mul_en;
  assign out_valid  = ctrl_a.out_valid;
  assign frame_done = ctrl_a.frame_done;

endmodule

// File: doc/twiddle_seq.md
TWIDDLE_SEQ -- requirements
Module: twiddle_seq

Interface
REQ-001 Parameter FFT_STAGE, default 1: 1-based R2SDF stage index, legal range 1..`C2LOG_FFT_POINTS; butterfly span D = 2^(`C2LOG_FFT_POINTS-FFT_STAGE).
REQ-002 Parameter TW_FF, default 1: read latency of the attached twiddle ROM, 0 or 1 cycles; the control outputs are aligned to it.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 start  input  1  one-cycle pulse that begins a frame; honoured only in IDLE.
REQ-006 in_valid  input  1  a stage input sample is accepted this cycle.
REQ-007 tw_addr  output  `C2LOG_FFT_POINTS  twiddle ROM address, unaligned, ROM-side.
REQ-008 bf_sel  output  1  0 = fill/pass-through phase, 1 = butterfly phase; aligned to ROM data.
REQ-009 mul_en  output  1  apply the ROM twiddle to the current delay-line output; aligned.
REQ-010 out_valid  output  1  the stage output sample is valid; aligned.
REQ-011 busy  output  1  high in RUN and FLUSH.
REQ-012 frame_done  output  1  one-cycle pulse on the final FLUSH step; aligned.

Function
REQ-013 FSM states: IDLE, RUN, FLUSH; encoding constants live in the shared package.
REQ-014 IDLE->RUN on start; in RUN, in_valid is ignored on the start cycle itself.
REQ-015 In RUN, each in_valid cycle advances the step counter cnt (`C2LOG_FFT_POINTS bits, cleared on entry to RUN).
REQ-016 RUN->FLUSH on the cycle that accepts sample N-1 (cnt = N-1 with in_valid); cnt then wraps to 0.
REQ-017 In FLUSH, one step occurs per cycle regardless of in_valid; FLUSH->IDLE after D steps.
REQ-018 Phase per step: ph = bit (`C2LOG_FFT_POINTS-FFT_STAGE) of cnt; bf_sel = ph; FLUSH steps are ph = 0.
REQ-019 tw_addr = (cnt mod D) << (FFT_STAGE-1) when ph = 0 and a difference term is leaving the delay line; otherwise 0.
REQ-020 mul_en = 1 on ph = 0 steps, except the first D steps of a frame, where the delay line holds no difference; all FLUSH steps have mul_en = 1.
REQ-021 out_valid = 1 on every step after the first D steps of the frame, including all FLUSH steps, giving exactly N per frame.
REQ-022 Steps are qualified: in RUN without in_valid, cnt holds, tw_addr holds, and out_valid/mul_en are 0.
REQ-023 Alignment: with TW_FF = 1, bf_sel, mul_en, out_valid and frame_done are registered one extra cycle relative to tw_addr; with TW_FF = 0 they are concurrent.
REQ-024 start while busy is ignored; back-to-back frames need one IDLE cycle between them.
REQ-025 All arithmetic is unsigned; the shift in tw_addr never overflows because (cnt mod D)·2^(FFT_STAGE-1) < N/2.

Reset
REQ-026 rst_n low at any clock edge, mid-frame included, forces IDLE, cnt = 0, and all outputs plus the alignment registers to 0 on that edge; the interrupted frame is discarded.
REQ-027 The first start is accepted on the first edge with rst_n high.

Structure
REQ-028 The shared package (beside define.v) holds the FSM state constants and the derived D/stride width helpers; it uses `C2LOG_FFT_POINTS and `DATA_IN_WIDTH from define.v.
REQ-029 One natural sub-module, tw_align_pipe: a parameterised 0/1-cycle delay for the aligned control bits; the ROM itself stays external.

Verification (N = 16, FFT_STAGE = 2, D = 4, TW_FF = 1 unless stated)
REQ-030 start, then 16 consecutive in_valid -> tw_addr on mul_en steps = 0,2,4,6 repeating; out_valid count = 16; frame_done exactly once, 1 cycle after the last tw_addr.
REQ-031 in_valid deasserted every other cycle -> same address sequence, outputs only on qualified steps; busy stays high throughout.
REQ-032 rst_n low at sample 9 -> next edge all outputs 0 and state IDLE; a fresh start yields a clean frame identical to REQ-030.
REQ-033 start pulsed during RUN and FLUSH -> ignored; frame length is unchanged.
REQ-034 TW_FF = 0 -> bf_sel/mul_en/out_valid change in the same cycle as tw_addr; FFT_STAGE = 4 (D = 1) -> tw_addr stride 8, all addresses 0.
